// File: rtl/hazard_pkg.sv
// Shared definitions for the multi-cycle hazard controller: FSM encoding,
// the hardwired-zero register specifier and default latencies.
package hazard_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_RUN       = 1'b0;
  localparam state_t ST_LOAD_WAIT = 1'b1;

  localparam int unsigned REG_ZERO     = 0;
  localparam int unsigned DEF_LOAD_LAT = 1;
  localparam int unsigned DEF_MD_LAT   = 4;

  // Width needed to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/busy_timer.sv
// Loadable down-counter that stops at zero and flags a nonzero count.
// Load takes priority over the decrement.
module busy_timer
  import hazard_pkg::*;
#(
  parameter int unsigned MAX = DEF_MD_LAT,
  parameter int unsigned W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt,
  output logic         o_nz
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_nz  = (r_cnt != '0);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage pipeline: multi-bubble load-use stall,
// mult/div HI/LO busy window, taken-branch IF/ID flush and a stall counter.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
  parameter int unsigned MD_LAT   = DEF_MD_LAT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_EX_MemRead,
  input  logic [REG_AW-1:0] ID_EX_RegisterRt,
  input  logic [REG_AW-1:0] IF_ID_RegisterRs,
  input  logic [REG_AW-1:0] IF_ID_RegisterRt,
  input  logic              IF_ID_UsesRs,
  input  logic              IF_ID_UsesRt,
  input  logic              IF_ID_ReadsHiLo,
  input  logic              MulDiv_start,
  input  logic              Branch_taken,
  input  logic              stall_cnt_clr,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              Pipe_stall,
  output logic              IF_ID_Flush,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned       LD_W     = cnt_width(LOAD_LAT);
  localparam int unsigned       MD_W     = cnt_width(MD_LAT);
  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_ZERO);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load_hit;
  logic              w_hit_run;
  logic              w_ld_load;
  logic [LD_W-1:0]   w_ld_cnt;
  logic              w_ld_nz;
  logic [MD_W-1:0]   w_md_cnt;
  logic              w_md_nz;
  logic              w_md_stall;
  logic              w_stall_raw;
  logic              w_stall;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic              w_unused;

  assign w_load_hit = ID_EX_MemRead && (ID_EX_RegisterRt != ZERO_REG) &&
                      ((IF_ID_UsesRs && (ID_EX_RegisterRt == IF_ID_RegisterRs)) ||
                       (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

  assign w_hit_run = w_load_hit && (r_state == ST_RUN);

  // With a single bubble the stall cycle itself clears MemRead, so no wait state.
  assign w_ld_load = w_hit_run && (LOAD_LAT > 1);

  busy_timer #(
    .MAX (LOAD_LAT),
    .W   (LD_W)
  ) u_ld_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_ld_load),
    .i_load_val (LD_W'(LOAD_LAT - 1)),
    .o_cnt      (w_ld_cnt),
    .o_nz       (w_ld_nz)
  );

  busy_timer #(
    .MAX (MD_LAT),
    .W   (MD_W)
  ) u_md_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (MulDiv_start),
    .i_load_val (MD_W'(MD_LAT)),
    .o_cnt      (w_md_cnt),
    .o_nz       (w_md_nz)
  );

  assign w_unused = ^{w_ld_nz, w_md_cnt};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_ld_load) w_state_nxt = ST_LOAD_WAIT;
      end
      ST_LOAD_WAIT: begin
        if (w_ld_cnt == LD_W'(1)) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_md_stall  = w_md_nz && IF_ID_ReadsHiLo;
  assign w_stall_raw = w_hit_run || (r_state == ST_LOAD_WAIT) || w_md_stall;

  // Gate with reset so outputs show the idle pipeline while reset is held,
  // whatever the ID/EX inputs happen to carry.
  assign w_stall = rst_n && w_stall_raw;

  assign PCWrite     = !w_stall;
  assign IF_ID_Write = !w_stall;
  assign Pipe_stall  = w_stall;
  assign IF_ID_Flush = rst_n && Branch_taken && !w_stall_raw;
  assign md_busy     = w_md_nz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (stall_cnt_clr) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: two instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) driven by shared vectors with a scoreboard queue.
module tb_hazard_ctrl_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mr;
  logic [4:0] ldrt, rs, rt;
  logic       urs, urt, hilo, mds, br, clr;

  logic        pcw1, ifw1, ps1, fl1, mb1;
  logic [15:0] sc1;
  logic        pcw3, ifw3, ps3, fl3, mb3;
  logic [3:0]  sc3;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(
    .REG_AW   (5),
    .LOAD_LAT (1),
    .MD_LAT   (4),
    .CNT_W    (16)
  ) dut1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .ID_EX_MemRead    (mr),
    .ID_EX_RegisterRt (ldrt),
    .IF_ID_RegisterRs (rs),
    .IF_ID_RegisterRt (rt),
    .IF_ID_UsesRs     (urs),
    .IF_ID_UsesRt     (urt),
    .IF_ID_ReadsHiLo  (hilo),
    .MulDiv_start     (mds),
    .Branch_taken     (br),
    .stall_cnt_clr    (clr),
    .PCWrite          (pcw1),
    .IF_ID_Write      (ifw1),
    .Pipe_stall       (ps1),
    .IF_ID_Flush      (fl1),
    .md_busy          (mb1),
    .stall_cycles     (sc1)
  );

  hazard_ctrl_mc #(
    .REG_AW   (5),
    .LOAD_LAT (3),
    .MD_LAT   (4),
    .CNT_W    (4)
  ) dut3 (
    .clk              (clk),
    .rst_n            (rst_n),
    .ID_EX_MemRead    (mr),
    .ID_EX_RegisterRt (ldrt),
    .IF_ID_RegisterRs (rs),
    .IF_ID_RegisterRt (rt),
    .IF_ID_UsesRs     (urs),
    .IF_ID_UsesRt     (urt),
    .IF_ID_ReadsHiLo  (hilo),
    .MulDiv_start     (mds),
    .Branch_taken     (br),
    .stall_cnt_clr    (clr),
    .PCWrite          (pcw3),
    .IF_ID_Write      (ifw3),
    .Pipe_stall       (ps3),
    .IF_ID_Flush      (fl3),
    .md_busy          (mb3),
    .stall_cycles     (sc3)
  );

  typedef struct {
    logic        mr;
    logic [4:0]  ldrt, rs, rt;
    logic        urs, urt, hilo, mds, br, clr;
    logic        s1, f1;
    logic [15:0] c1;
    logic        s3, f3;
    logic [3:0]  c3;
    logic        busy;
  } vec_t;

  typedef struct {
    int unsigned idx;
    logic [20:0] o1;
    logic [8:0]  o3;
  } exp_t;

  localparam int NV = 35;
  vec_t vecs[NV];
  exp_t sb[$];

  function automatic vec_t mk(
    input logic mr_v, input logic [4:0] ldrt_v, input logic [4:0] rs_v, input logic [4:0] rt_v,
    input logic urs_v, input logic urt_v, input logic hilo_v, input logic mds_v,
    input logic br_v, input logic clr_v,
    input logic s1_v, input logic f1_v, input logic [15:0] c1_v,
    input logic s3_v, input logic f3_v, input logic [3:0] c3_v, input logic busy_v);
    vec_t v;
    v.mr = mr_v; v.ldrt = ldrt_v; v.rs = rs_v; v.rt = rt_v;
    v.urs = urs_v; v.urt = urt_v; v.hilo = hilo_v; v.mds = mds_v;
    v.br = br_v; v.clr = clr_v;
    v.s1 = s1_v; v.f1 = f1_v; v.c1 = c1_v;
    v.s3 = s3_v; v.f3 = f3_v; v.c3 = c3_v; v.busy = busy_v;
    return v;
  endfunction

  function automatic logic [20:0] exp1(input logic s, input logic f, input logic b,
                                       input logic [15:0] c);
    return {~s, ~s, s, f, b, c};
  endfunction

  function automatic logic [8:0] exp3(input logic s, input logic f, input logic b,
                                      input logic [3:0] c);
    return {~s, ~s, s, f, b, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    mr = 0; ldrt = 0; rs = 0; rt = 0; urs = 0; urt = 0;
    hilo = 0; mds = 0; br = 0; clr = 0;
  endtask

  task automatic apply(input vec_t v);
    mr = v.mr; ldrt = v.ldrt; rs = v.rs; rt = v.rt; urs = v.urs; urt = v.urt;
    hilo = v.hilo; mds = v.mds; br = v.br; clr = v.clr;
  endtask

  initial begin
    exp_t e;

    //             mr ldrt rs rt urs urt hl mds br clr  s1 f1 c1  s3 f3 c3 busy
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0);
    vecs[1]  = mk(1, 5, 5, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0,  1, 0, 0,  0);
    vecs[2]  = mk(0, 0, 5, 0, 1, 0, 0, 0, 0, 0,  0, 0, 1,  1, 0, 1,  0);
    vecs[3]  = mk(0, 0, 5, 0, 1, 0, 0, 0, 0, 0,  0, 0, 1,  1, 0, 2,  0);
    vecs[4]  = mk(0, 0, 5, 0, 1, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 3,  0);
    vecs[5]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 3,  0);
    vecs[6]  = mk(1, 7, 3, 7, 1, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 3,  0);
    vecs[7]  = mk(1, 7, 3, 7, 1, 1, 0, 0, 0, 0,  1, 0, 1,  1, 0, 3,  0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2,  1, 0, 4,  0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2,  1, 0, 5,  0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2,  0, 0, 6,  0);
    vecs[11] = mk(1, 9, 9, 0, 1, 0, 0, 0, 1, 0,  1, 0, 2,  1, 0, 6,  0);
    vecs[12] = mk(0, 0, 9, 0, 1, 0, 0, 0, 1, 0,  0, 1, 3,  1, 0, 7,  0);
    vecs[13] = mk(0, 0, 9, 0, 1, 0, 0, 0, 1, 0,  0, 1, 3,  1, 0, 8,  0);
    vecs[14] = mk(0, 0, 9, 0, 1, 0, 0, 0, 1, 0,  0, 1, 3,  0, 1, 9,  0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3,  0, 0, 9,  0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 3,  0, 0, 9,  0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3,  0, 0, 9,  1);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 3,  1, 0, 9,  1);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 4,  1, 0, 10, 1);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 5,  1, 0, 11, 1);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 6,  0, 0, 12, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 6,  0, 0, 12, 0);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 6,  0, 0, 12, 0);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 6,  0, 0, 12, 1);
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 6,  0, 0, 12, 1);
    vecs[26] = mk(1, 4, 4, 0, 1, 0, 1, 0, 0, 0,  1, 0, 6,  1, 0, 12, 1);
    vecs[27] = mk(0, 0, 4, 0, 1, 0, 1, 0, 0, 0,  1, 0, 7,  1, 0, 13, 1);
    vecs[28] = mk(0, 0, 4, 0, 1, 0, 1, 0, 0, 0,  1, 0, 8,  1, 0, 14, 1);
    vecs[29] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 9,  1, 0, 15, 1);
    vecs[30] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 10, 0, 0, 15, 0);
    vecs[31] = mk(1, 6, 6, 0, 1, 0, 0, 0, 0, 0,  1, 0, 10, 1, 0, 15, 0);
    vecs[32] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 11, 1, 0, 15, 0);
    vecs[33] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 11, 1, 0, 15, 0);
    vecs[34] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0);

    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_dut1", 32'({pcw1, ifw1, ps1, fl1, mb1, sc1}), 32'(exp1(0, 0, 0, 16'd0)));
    check("reset_dut3", 32'({pcw3, ifw3, ps3, fl3, mb3, sc3}), 32'(exp3(0, 0, 0, 4'd0)));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      apply(vecs[i]);
      e.idx = i;
      e.o1  = exp1(vecs[i].s1, vecs[i].f1, vecs[i].busy, vecs[i].c1);
      e.o3  = exp3(vecs[i].s3, vecs[i].f3, vecs[i].busy, vecs[i].c3);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("vec%0d_dut1", e.idx), 32'({pcw1, ifw1, ps1, fl1, mb1, sc1}), 32'(e.o1));
      check($sformatf("vec%0d_dut3", e.idx), 32'({pcw3, ifw3, ps3, fl3, mb3, sc3}), 32'(e.o3));
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Reset asserted while dut3 sits in LOAD_WAIT with a live hazard on the inputs.
    @(posedge clk);
    #1;
    idle();
    mds = 1;
    @(posedge clk);
    #1;
    mds = 0; mr = 1; ldrt = 2; rs = 2; urs = 1;
    @(negedge clk);
    check("mid_hit_dut1", 32'({pcw1, ifw1, ps1, fl1, mb1, sc1}), 32'(exp1(1, 0, 1, 16'd0)));
    check("mid_hit_dut3", 32'({pcw3, ifw3, ps3, fl3, mb3, sc3}), 32'(exp3(1, 0, 1, 4'd0)));
    @(posedge clk);
    #1;
    mr = 0;
    @(negedge clk);
    check("mid_wait_dut3", 32'({pcw3, ifw3, ps3, fl3, mb3, sc3}), 32'(exp3(1, 0, 1, 4'd1)));
    #2;
    mr = 1; br = 1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_dut1", 32'({pcw1, ifw1, ps1, fl1, mb1, sc1}), 32'(exp1(0, 0, 0, 16'd0)));
    check("rst_mid_dut3", 32'({pcw3, ifw3, ps3, fl3, mb3, sc3}), 32'(exp3(0, 0, 0, 4'd0)));
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_dut3", k), 32'({pcw3, ifw3, ps3, fl3, mb3, sc3}),
            32'(exp3(0, 0, 0, 4'd0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
